// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline bundles
// for the pipe_mips32 core.
package mips32_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;
   localparam logic [5:0] OP_NOP   = 6'b110000;

   localparam logic [31:0] NOP_IR = {OP_NOP, 26'b0};

   typedef enum logic [2:0] {
      NONE, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
   } cls_t;

   typedef enum logic [2:0] {
      A_ADD, A_SUB, A_AND, A_OR, A_SLT, A_MUL
   } aop_t;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] npc;
   } if_id_t;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] npc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      cls_t        cls;
      aop_t        aop;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic        wr;
   } id_ex_t;

   typedef struct packed {
      cls_t        cls;
      logic [31:0] alu;
      logic [31:0] b;
      logic [4:0]  dst;
      logic        wr;
   } ex_mem_t;

   typedef struct packed {
      cls_t        cls;
      logic [31:0] alu;
      logic [31:0] lmd;
      logic [4:0]  dst;
      logic        wr;
   } mem_wb_t;

   localparam if_id_t IF_ID_NOP = '{ir: NOP_IR, npc: '0};

   localparam id_ex_t ID_EX_NOP = '{
      op: OP_NOP, npc: '0, a: '0, b: '0, imm: '0,
      cls: NONE, aop: A_ADD, rs: '0, rt: '0,
      dst: '0, wr: 1'b0};

   localparam ex_mem_t EX_MEM_NOP = '{
      cls: NONE, alu: '0, b: '0, dst: '0, wr: 1'b0};

   localparam mem_wb_t MEM_WB_NOP = '{
      cls: NONE, alu: '0, lmd: '0, dst: '0, wr: 1'b0};

   function automatic cls_t cls_of(input logic [5:0] op);
      cls_t c;
      unique case (1'b1)
         (op inside {OP_ADD, OP_SUB, OP_AND,
                     OP_OR, OP_SLT, OP_MUL}): c = RR_ALU;
         (op inside {OP_ADDI, OP_SUBI, OP_SLTI}): c = RM_ALU;
         (op == OP_LW): c = LOAD;
         (op == OP_SW): c = STORE;
         (op inside {OP_BNEQZ, OP_BEQZ}): c = BRANCH;
         (op == OP_HLT): c = HALT;
         default: c = NONE;
      endcase
      return c;
   endfunction

   function automatic aop_t aop_of(input logic [5:0] op);
      aop_t a;
      unique case (1'b1)
         (op == OP_SUB || op == OP_SUBI): a = A_SUB;
         (op == OP_AND): a = A_AND;
         (op == OP_OR): a = A_OR;
         (op == OP_SLT || op == OP_SLTI): a = A_SLT;
         (op == OP_MUL): a = A_MUL;
         default: a = A_ADD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/mips32_if.sv
// Core status bundle: halt flag and taken-branch pulse.
interface mips32_if;
   logic halted;
   logic taken;
   modport master (output halted, output taken);
   modport slave (input halted, input taken);
endinterface

// File: rtl/mips32_alu.sv
// Combinational integer ALU shared by all EX-stage ops.
module mips32_alu
   import mips32_pkg::*;
(
   input  aop_t        aop,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   always_comb begin
      y = '0;
      unique case (aop)
         A_ADD: y = a + b;
         A_SUB: y = a - b;
         A_AND: y = a & b;
         A_OR:  y = a | b;
         A_SLT: y = {31'b0, $signed(a) < $signed(b)};
         A_MUL: y = a * b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/pipe_mips32.sv
// 5-stage MIPS-style core with EX forwarding, EX-resolved
// branches and a retire-time halt; Reg and Mem live here.
module pipe_mips32
   import mips32_pkg::*;
(
   input  logic     clk1,
   input  logic     rst,
   mips32_if.master bus
);

   logic [31:0] Reg [0:31];
   logic [31:0] Mem [0:1023];
   logic [31:0] PC;
   logic        HALTED;
   logic        TAKEN_BRANCH;

   if_id_t  if_id;
   id_ex_t  id_ex, id_d;
   ex_mem_t ex_mem;
   mem_wb_t mem_wb;

   logic [31:0] wb_val, rda, rdb;
   logic [31:0] fa, fb, opb, alu_y, target;
   logic [4:0]  ra, rb;
   logic        wb_we, taken, stop;

   assign wb_val = (mem_wb.cls == LOAD) ? mem_wb.lmd
                                        : mem_wb.alu;
   assign wb_we  = mem_wb.wr && !HALTED;

   // Register read with write-through from WB.
   assign ra  = if_id.ir[25:21];
   assign rb  = if_id.ir[20:16];
   assign rda = (ra == '0) ? '0
              : (wb_we && mem_wb.dst == ra) ? wb_val
              : Reg[ra];
   assign rdb = (rb == '0) ? '0
              : (wb_we && mem_wb.dst == rb) ? wb_val
              : Reg[rb];

   always_comb begin
      id_d     = ID_EX_NOP;
      id_d.op  = if_id.ir[31:26];
      id_d.npc = if_id.npc;
      id_d.a   = rda;
      id_d.b   = rdb;
      id_d.imm = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
      id_d.cls = cls_of(if_id.ir[31:26]);
      id_d.aop = aop_of(if_id.ir[31:26]);
      id_d.rs  = ra;
      id_d.rt  = rb;
      id_d.dst = (id_d.cls == RR_ALU) ? if_id.ir[15:11]
                                      : rb;
      id_d.wr  = (id_d.cls inside {RR_ALU, RM_ALU, LOAD})
              && (id_d.dst != '0);
   end

   // Youngest producer wins; a load is only visible from MEM/WB.
   always_comb begin
      fa = id_ex.a;
      if (ex_mem.wr && ex_mem.cls != LOAD
          && ex_mem.dst == id_ex.rs)
         fa = ex_mem.alu;
      else if (mem_wb.wr && mem_wb.dst == id_ex.rs)
         fa = wb_val;
   end

   always_comb begin
      fb = id_ex.b;
      if (ex_mem.wr && ex_mem.cls != LOAD
          && ex_mem.dst == id_ex.rt)
         fb = ex_mem.alu;
      else if (mem_wb.wr && mem_wb.dst == id_ex.rt)
         fb = wb_val;
   end

   assign opb = (id_ex.cls == RR_ALU) ? fb : id_ex.imm;

   mips32_alu u_alu (
      .aop (id_ex.aop),
      .a   (fa),
      .b   (opb),
      .y   (alu_y)
   );

   assign target = id_ex.npc + id_ex.imm;
   assign taken  = (id_ex.cls == BRANCH)
                && ((id_ex.op == OP_BEQZ) ? (fa == '0)
                                          : (fa != '0));
   assign stop   = (id_d.cls == HALT) || (id_ex.cls == HALT)
                || (ex_mem.cls == HALT) || (mem_wb.cls == HALT);

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         PC           <= '0;
         HALTED       <= 1'b0;
         TAKEN_BRANCH <= 1'b0;
         if_id        <= IF_ID_NOP;
         id_ex        <= ID_EX_NOP;
         ex_mem       <= EX_MEM_NOP;
         mem_wb       <= MEM_WB_NOP;
      end else if (!HALTED) begin
         TAKEN_BRANCH <= taken;
         if (mem_wb.cls == HALT)
            HALTED <= 1'b1;
         // A taken branch outranks a younger HLT sitting in ID.
         if (taken) begin
            PC    <= target;
            if_id <= IF_ID_NOP;
            id_ex <= ID_EX_NOP;
         end else begin
            id_ex <= id_d;
            if (stop) begin
               if_id <= IF_ID_NOP;
            end else begin
               if_id <= '{ir: Mem[PC[9:0]], npc: PC + 1};
               PC    <= PC + 1;
            end
         end
         ex_mem <= '{cls: id_ex.cls, alu: alu_y, b: fb,
                     dst: id_ex.dst, wr: id_ex.wr};
         mem_wb <= '{cls: ex_mem.cls, alu: ex_mem.alu,
                     lmd: Mem[ex_mem.alu[9:0]],
                     dst: ex_mem.dst, wr: ex_mem.wr};
      end
   end

   always_ff @(posedge clk1) begin
      if (!rst && wb_we)
         Reg[mem_wb.dst] <= wb_val;
      if (!rst && !HALTED && ex_mem.cls == STORE)
         Mem[ex_mem.alu[9:0]] <= ex_mem.b;
   end

   assign bus.halted = HALTED;
   assign bus.taken  = TAKEN_BRANCH;

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed program bench for pipe_mips32: preloads Mem/Reg,
// runs to halt, and compares architectural state.
module tb_pipe_mips32;

   logic clk1 = 1'b0;
   logic rst  = 1'b1;

   mips32_if bus ();

   pipe_mips32 dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 clk1 = ~clk1;

   typedef struct {
      int          kind;
      int          idx;
      logic [31:0] exp;
   } vec_t;

   vec_t        vq[$];
   logic [31:0] prog[$];
   int          n_pass = 0;
   int          n_chk  = 0;
   int          edges;
   int          tk_cnt;
   int          bad;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h",
                    name, act, exp);
   endtask

   task automatic add(input int kind, input int idx,
                      input logic [31:0] exp);
      vec_t v;
      v.kind = kind;
      v.idx  = idx;
      v.exp  = exp;
      vq.push_back(v);
   endtask

   task automatic setup();
      @(negedge clk1);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 1024; i++) dut.Mem[i] = '0;
      for (int i = 0; i < prog.size(); i++)
         dut.Mem[i] = prog[i];
      for (int k = 0; k < 32; k++) dut.Reg[k] = k;
   endtask

   task automatic run(input string tag, input int limit);
      @(negedge clk1);
      rst    = 1'b0;
      edges  = 0;
      tk_cnt = 0;
      while (edges < limit) begin
         @(posedge clk1);
         #1;
         edges++;
         if (bus.taken) tk_cnt++;
         if (bus.halted) break;
      end
      check({tag, "_halt"}, {31'b0, bus.halted}, 32'd1);
   endtask

   task automatic verify(input string tag);
      logic [31:0] act;
      for (int i = 0; i < vq.size(); i++) begin
         act = (vq[i].kind == 1) ? dut.Mem[vq[i].idx]
                                 : dut.Reg[vq[i].idx];
         check($sformatf("%s_%s%0d", tag,
                         (vq[i].kind == 1) ? "M" : "R",
                         vq[i].idx), act, vq[i].exp);
      end
      vq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Basic program from preloaded Reg[k]=k.
      prog = '{32'h2801000a, 32'h28020014, 32'h28030019,
               32'h0ce77800, 32'h0ce77800, 32'h00222000,
               32'h0ce77800, 32'h00832800, 32'hfc000000};
      setup();
      check("reset_pc", dut.PC, 32'd0);
      check("reset_halted", {31'b0, bus.halted}, 32'd0);
      run("basic", 200);
      check("basic_edges", edges, 32'd13);
      add(0, 0, 0);  add(0, 1, 10); add(0, 2, 20);
      add(0, 3, 25); add(0, 4, 30); add(0, 5, 55);
      add(0, 15, 7);
      verify("basic");

      // Back-to-back forwarding.
      prog = '{32'h28010005, 32'h00211000, 32'h00411800,
               32'hfc000000};
      setup();
      run("fwd", 200);
      check("fwd_edges", edges, 32'd8);
      add(0, 1, 5); add(0, 2, 10); add(0, 3, 15);
      verify("fwd");

      // Load, one-slot gap, forward into ALU and store.
      prog = '{32'h20020064, 32'h00000000, 32'h28430001,
               32'h24030065, 32'hfc000000};
      setup();
      dut.Mem[100] = 32'd77;
      run("ls", 200);
      add(0, 2, 77); add(0, 3, 78);
      add(1, 101, 78); add(1, 100, 77);
      verify("ls");

      // Branch loop; HLT in ID is flushed on taken iterations.
      prog = '{32'h28420002, 32'h2c210001, 32'h3421fffd,
               32'hfc000000, 32'h28080063};
      setup();
      dut.Reg[1] = 32'd3;
      dut.Reg[2] = 32'd0;
      run("loop", 500);
      check("loop_taken_pulses", tk_cnt, 32'd2);
      add(0, 1, 0); add(0, 2, 6); add(0, 8, 8);
      verify("loop");

      // Halt freezes PC, Reg and the halt flag.
      prog = '{32'hfc000000, 32'h28090001};
      setup();
      run("hlt", 200);
      check("hlt_pc", dut.PC, 32'd1);
      bad = 0;
      repeat (20) begin
         @(posedge clk1);
         #1;
         if (!bus.halted || dut.PC != 32'd1) bad++;
      end
      check("hlt_hold", bad, 32'd0);
      add(0, 9, 9);
      verify("hlt");

      // Reset in the middle of a long loop.
      prog = '{32'h28420002, 32'h2c210001, 32'h3421fffd,
               32'hfc000000, 32'h28080063};
      setup();
      dut.Reg[1] = 32'd100;
      dut.Reg[2] = 32'd0;
      @(negedge clk1);
      rst = 1'b0;
      repeat (50) @(posedge clk1);
      @(negedge clk1);
      rst = 1'b1;
      #1;
      check("mid_rst_pc", dut.PC, 32'd0);
      check("mid_rst_halted", {31'b0, bus.halted}, 32'd0);
      check("mid_rst_taken", {31'b0, bus.taken}, 32'd0);
      @(negedge clk1);
      @(negedge clk1);
      rst = 1'b0;
      @(posedge clk1);
      #1;
      check("mid_restart_pc1", dut.PC, 32'd1);
      @(posedge clk1);
      #1;
      check("mid_restart_pc2", dut.PC, 32'd2);
      edges = 0;
      while (edges < 2000 && !bus.halted) begin
         @(posedge clk1);
         #1;
         edges++;
      end
      check("mid_halt", {31'b0, bus.halted}, 32'd1);
      add(0, 1, 0); add(0, 8, 8);
      verify("mid");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_mips32.md
# pipe_mips32

Single-clock, 5-stage (IF/ID/EX/MEM/WB) pipelined 32-bit MIPS-style integer core with a unified word-addressed instruction/data memory and a 32×32 register file held internally. It is the processor block of the design; program and data are preloaded hierarchically into `Mem` and `Reg`, and execution runs until a HLT instruction retires.

## Interface
- No parameters. Memory depth is fixed at 1024 words and the register file at 32 registers.
- `clk1  in  1`: the single core clock; all state updates on its rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `halted  out  1`: equals internal `HALTED`; 1 once HLT has retired.
- Hierarchically accessible state, names fixed: `Reg[0:31]` (32b), `Mem[0:1023]` (32b), `PC` (32b), `HALTED`, `TAKEN_BRANCH`.

## Operation
- **Instruction fields:** opcode `[31:26]`, rs `[25:21]`, rt `[20:16]`, rd `[15:11]`, imm `[15:0]`. imm is sign-extended to 32 bits.
- **Register-register ALU ops** (rd ← rs op rt): ADD `000000`, SUB `000001`, AND `000010`, OR `000011`, SLT `000100` (signed, result 1/0), MUL `000101` (low 32 bits).
- **Register-immediate ALU ops** (rt ← rs op imm): ADDI `001010`, SUBI `001011`, SLTI `001100` (signed).
- **Memory:** LW `001000`: rt ← Mem[rs+imm]. SW `001001`: Mem[rs+imm] ← rt. The address uses bits `[9:0]` of the sum.
- **Branches:** BNEQZ `001101` and BEQZ `001110` test rs against zero. The target is PC_of_branch + 1 + imm, in words.
- **HLT** `111111`.
- **Undefined opcodes:** executed as NOPs. They write nothing.
- **R0:** reads always return 0. Writes to R0 are discarded.
- **Register file:** written in WB. A same-cycle read of the register being written returns the new value (write-through).
- **Forwarding:** results in EX/MEM and MEM/WB are forwarded to the EX operands (rs, and rt including SW data). The youngest producer wins.
- **Load-use:** a load result is forwardable only from MEM/WB. Software must place ≥1 instruction between an LW and its consumer. There is no interlock.
- **Taken branch:**
  - Resolved in EX.
  - PC ← target; `TAKEN_BRANCH` pulses high for 1 cycle.
  - The two younger instructions (in IF/ID and ID/EX) become bubbles. Bubbles perform no register or memory writes.
- **HLT handling:**
  - When HLT is in ID, fetch stops and PC holds. Bubbles are injected into IF/ID.
  - Older instructions complete normally.
  - When HLT reaches WB, `HALTED` ← 1.
  - While `HALTED`=1, no state changes: no fetch, no register/memory writes.
- **Taken branch vs HLT:** a taken branch in EX that is older than an HLT in ID flushes that HLT, and fetch resumes at the target.

## Timing
- **Reset (async assert):** PC=0, `HALTED`=0, `TAKEN_BRANCH`=0, all pipeline registers hold bubbles. `Reg` and `Mem` are not reset.
- **Throughput:** 1 instruction per cycle, apart from branch flushes (2-cycle penalty) and halt.
- **Latency:** an instruction fetched on rising edge n writes the register file on edge n+4.
- **Halt timing:** HLT fetched at edge n sets `halted` after edge n+4.
- **Reset mid-run:** aborts all in-flight instructions. Partial writes already committed to `Reg`/`Mem` remain.
- **Simultaneous SW/LW to the same address:** when the SW is in MEM while an older LW has already passed MEM, the LW keeps its old value. Memory order is program order.

## Structure
- **Package `mips32_pkg`:**
  - 6-bit opcode constants.
  - Instruction-class enum: RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT.
  - Bubble/NOP encoding.
- **Sub-module `mips32_alu`:** combinational op + two 32b operands → 32b result.
- **Top level:** holds the pipeline registers, forwarding muxes, flush/halt control, `Reg` and `Mem`.

## Test plan
- **Basic program:** preload `Reg[k]=k` and the program `2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000`; pulse rst.
  - Expected: R0=0, R1=10, R2=20, R3=25, R4=30, R5=55.
  - `halted`=1 after edge 13.
- **Back-to-back forwarding:** ADDI R1,R0,5; ADD R2,R1,R1; ADD R3,R2,R1; HLT → R2=10, R3=15.
- **Load/store:** Mem[100]=77; LW R2,100(R0); NOP; ADDI R3,R2,1; SW R3,101(R0); HLT → R2=77, R3=78, Mem[101]=78.
- **Branch loop:** R1=3, R2=0; loop: ADDI R2,R2,2; SUBI R1,R1,1; BNEQZ R1,−3; then HLT.
  - Expected: R2=6, R1=0.
  - The two instructions after the BNEQZ never write state on taken iterations.
- **Halt freezing:** HLT followed by ADDI R9,R0,1 → R9 unchanged; PC frozen; `halted` stays 1 for ≥20 cycles.
- **Reset mid-operation:** assert rst during the loop, then release → PC=0, `halted`=0, and execution restarts from Mem[0].
